// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter for the single data-memory port.
// One transaction in flight at a time; round-robin on contention; timeout error response.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_gnt,
  output logic          o_if_rvalid,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_err,
  input  logic          i_ls_req,
  input  logic          i_ls_wen,
  input  logic [AW-1:0] i_ls_addr,
  input  logic [DW-1:0] i_ls_wdata,
  input  logic [MW-1:0] i_ls_wmask,
  output logic          o_ls_gnt,
  output logic          o_ls_rvalid,
  output logic [DW-1:0] o_ls_rdata,
  output logic          o_ls_err,
  output logic          o_mem_req,
  output logic          o_mem_wen,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [MW-1:0] o_mem_wmask,
  input  logic          i_mem_gnt,
  input  logic          i_mem_rvalid,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          last_ls_q, last_ls_d;
  logic          owner_ls_q, owner_ls_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [MW-1:0] wmask_q, wmask_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          if_gnt, ls_gnt;
  logic [8:0]    cnt_inc;
  logic          timeout_hit;

  // Grants are suppressed while reset is held so every output reads 0.
  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (state_q == S_IDLE && !i_rst) begin
      if (i_if_req && i_ls_req) begin
        if (last_ls_q) if_gnt = 1'b1;
        else           ls_gnt = 1'b1;
      end else if (i_if_req) begin
        if_gnt = 1'b1;
      end else if (i_ls_req) begin
        ls_gnt = 1'b1;
      end
    end
  end

  // The cycle that would bring the counter to TIMEOUT is the last one allowed in REQ+WAIT.
  assign cnt_inc     = {1'b0, cnt_q} + 9'd1;
  assign timeout_hit = (cnt_inc == TO_LIM);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ls_d  = last_ls_q;
    owner_ls_d = owner_ls_q;
    wen_d      = wen_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (if_gnt) begin
          state_d    = S_REQ;
          cnt_d      = 8'd0;
          last_ls_d  = 1'b0;
          owner_ls_d = 1'b0;
          wen_d      = 1'b0;
          addr_d     = i_if_addr;
          wdata_d    = '0;
          wmask_d    = '0;
        end else if (ls_gnt) begin
          state_d    = S_REQ;
          cnt_d      = 8'd0;
          last_ls_d  = 1'b1;
          owner_ls_d = 1'b1;
          wen_d      = i_ls_wen;
          addr_d     = i_ls_addr;
          wdata_d    = i_ls_wdata;
          wmask_d    = i_ls_wmask;
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc[7:0];
        if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (i_mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[7:0];
        if (i_mem_rvalid) begin
          state_d = S_RESP;
          err_d   = 1'b0;
          rdata_d = wen_q ? '0 : i_mem_rdata;
        end else if (timeout_hit) begin
          state_d = S_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      last_ls_q  <= 1'b1;
      owner_ls_q <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ls_q  <= last_ls_d;
      owner_ls_q <= owner_ls_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign o_if_gnt    = if_gnt;
  assign o_ls_gnt    = ls_gnt;
  assign o_mem_req   = (state_q == S_REQ);
  assign o_mem_wen   = wen_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;

  assign o_if_rvalid = (state_q == S_RESP) && !owner_ls_q;
  assign o_ls_rvalid = (state_q == S_RESP) &&  owner_ls_q;
  assign o_if_rdata  = o_if_rvalid ? rdata_q : '0;
  assign o_ls_rdata  = o_ls_rvalid ? rdata_q : '0;
  assign o_if_err    = o_if_rvalid & err_q;
  assign o_ls_err    = o_ls_rvalid & err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It accepts one transaction at a time from either side, sequences it onto the memory port (request, grant, response), routes the response back to the originating requester, and reports a timeout error if memory never answers. It sits between the core's fetch/LSU stages and the memory interface. It replaces direct per-unit memory access.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `MW`, 8, write byte-mask width; matches the LSU store mask
- `TIMEOUT`, 255, maximum number of cycles spent in REQ+WAIT before an error response is returned; range 1..255

- `i_clk`  in  1  clock; all state changes on the rising edge
- `i_rst`  in  1  asynchronous, active-high reset
- `i_if_req`  in  1  IFU read request
- `i_if_addr`  in  AW  IFU read address
- `o_if_gnt`  out  1  IFU request accepted this cycle (combinational)
- `o_if_rvalid`  out  1  IFU response valid, one-cycle pulse
- `o_if_rdata`  out  DW  IFU read data
- `o_if_err`  out  1  IFU response is a timeout error; qualified by `o_if_rvalid`
- `i_ls_req`  in  1  LSU request
- `i_ls_wen`  in  1  1 = store, 0 = load
- `i_ls_addr`  in  AW  LSU address
- `i_ls_wdata`  in  DW  store data
- `i_ls_wmask`  in  MW  store byte mask
- `o_ls_gnt`, `o_ls_rvalid`, `o_ls_rdata`, `o_ls_err`  out  1/1/DW/1  same meaning as the IFU ports, for the LSU
- `o_mem_req`  out  1  memory request
- `o_mem_wen`, `o_mem_addr`, `o_mem_wdata`, `o_mem_wmask`  out  1/AW/DW/MW  latched transaction fields
- `i_mem_gnt`  in  1  memory accepted the request
- `i_mem_rvalid`  in  1  memory response; also serves as the write acknowledge
- `i_mem_rdata`  in  DW  memory read data

## Operation
- FSM states:
  - IDLE → REQ on a grant.
  - REQ → WAIT when `i_mem_gnt`=1.
  - WAIT → RESP when `i_mem_rvalid`=1.
  - RESP → IDLE unconditionally.
  - REQ or WAIT → RESP with error when the timeout counter reaches `TIMEOUT`.
- Grants:
  - Issued only in IDLE. `o_if_gnt`/`o_ls_gnt` are combinational from the requests and `last_ls`. At most one is high.
  - A transfer occurs when req and gnt are both high in the same cycle.
  - At that edge the arbiter latches the owner (IF/LS), addr, wen, wdata and wmask, and loads the timeout counter with 0.
  - For an IFU transaction the latched values are wen=0, wdata=0, wmask=0.
- Arbitration:
  - A single requester is granted immediately.
  - When both request, the requester that was not granted last wins (round-robin).
  - `last_ls` updates on every grant. Its reset value is 1, so the first contention goes to the IFU.
- REQ state:
  - `o_mem_req`=1, driven with the latched fields; these stay stable until `i_mem_gnt`.
- WAIT state:
  - `o_mem_req`=0; the arbiter waits for `i_mem_rvalid`.
  - `i_mem_rdata` is captured into a response register on `i_mem_rvalid`.
  - For a store, the captured data is ignored and rdata is reported as 0.
- RESP state:
  - The owner's `o_*_rvalid`=1 for exactly one cycle, with the registered rdata; `err`=0.
  - The other requester's rvalid stays 0.
- Timeout:
  - The 8-bit counter increments each cycle in REQ and WAIT.
  - When it equals `TIMEOUT`, the FSM goes to RESP with `err`=1 and rdata=0.
  - A late `i_mem_rvalid` arriving while not in WAIT is ignored.
- `i_mem_rvalid` is only honoured in WAIT. Memory must not assert it in the same cycle as `i_mem_gnt`.
- Requests seen outside IDLE are not granted. Requesters hold req and fields until granted.

## Timing
- Reset (asynchronous, any state):
  - FSM goes to IDLE; counter=0; `last_ls`=1; latched fields=0.
  - All outputs are 0 in the cycle following reset assertion, and they stay 0 while reset is held.
  - An in-flight transaction is dropped with no response.
- Minimum latency:
  - Request granted in cycle 0 → `o_mem_req` in cycle 1.
  - If `i_mem_gnt`=1 in cycle 1 and `i_mem_rvalid`=1 in cycle 2 → `o_*_rvalid` in cycle 3.
- Throughput and overlap:
  - Next grant no earlier than cycle 4, the first IDLE cycle after RESP.
  - A single outstanding transaction only; no overlap.
- Timeout response: appears in the cycle after the counter reaches `TIMEOUT`.
- Simultaneous requests arriving in the same IDLE cycle: exactly one gnt, chosen by `last_ls`.

## Test plan
- Reset mid-WAIT (LSU load outstanding, assert `i_rst`) → all outputs 0. After release, an IFU request is granted in its first IDLE cycle and `last_ls` behaves as 1.
- IFU read, addr `0x8000_0000`, memory grants immediately, `i_mem_rvalid` one cycle later with `0x1234_5678` → `o_if_rvalid`=1 in cycle 3 with rdata `0x1234_5678`, `err`=0. `o_ls_rvalid` stays 0.
- LSU store, addr `0x8000_0010`, wdata `0xDEAD_BEEF`, wmask `0x0F`, memory holds `i_mem_gnt` low for 5 cycles → `o_mem_*` stable for all 6 REQ cycles. `o_ls_rvalid` comes after the ack, with rdata 0.
- Both requesting continuously from reset → grants alternate IF, LS, IF, LS. Each response is returned only to its owner.
- Memory never asserts `i_mem_rvalid` with `TIMEOUT`=10 → `o_ls_err`=1 with rdata 0, 11 cycles after the grant. A stray `i_mem_rvalid` in the following IDLE cycle produces no response.
- `i_mem_rvalid` pulsed while in IDLE with no transaction outstanding → no `o_*_rvalid` pulse and no state change.
